// File: rtl/div_ctrl.sv
// Sequencing controller for the iterative divider. It holds operands for the core,
// stalls EX while a divide is in flight, and strobes the HI/LO write on completion.
module div_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic                  op_signed,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic                  flush,
    output logic                  dc_start,
    output logic                  dc_signed,
    output logic [DATA_W-1:0]     dc_a,
    output logic [DATA_W-1:0]     dc_b,
    output logic                  dc_annul,
    input  logic [2*DATA_W-1:0]   dc_result,
    input  logic                  dc_ready,
    output logic                  div_stall,
    output logic                  hilo_we,
    output logic [DATA_W-1:0]     hi_wdata,
    output logic [DATA_W-1:0]     lo_wdata,
    output logic                  err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             div_zero;
    logic             timeout_hit;

    // Qualifying with rst keeps the combinational stall low while reset is held.
    assign accept      = rst & (state == S_IDLE) & op_valid & ~flush;
    assign div_zero    = (op_b == '0);
    assign timeout_hit = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = div_zero ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (dc_ready || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dc_start  = 1'b0;
        dc_annul  = 1'b0;
        div_stall = 1'b0;
        hilo_we   = 1'b0;
        case (state)
            S_IDLE: div_stall = accept;
            S_WAIT: begin
                dc_start  = 1'b1;
                div_stall = ~flush;
                dc_annul  = flush | (~dc_ready & timeout_hit);
            end
            S_DONE: hilo_we = ~flush;
            default: ;
        endcase
    end

    // Operand capture, wait counter and result capture. Flush outranks a
    // simultaneous ready or timeout, so neither may touch the result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_a        <= '0;
            dc_b        <= '0;
            dc_signed   <= 1'b0;
            cnt         <= '0;
            hi_wdata    <= '0;
            lo_wdata    <= '0;
            err_timeout <= 1'b0;
        end else if (accept) begin
            dc_a      <= op_a;
            dc_b      <= op_b;
            dc_signed <= op_signed;
            cnt       <= '0;
            if (div_zero) begin
                hi_wdata <= op_a;
                lo_wdata <= '1;
            end
        end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
            if (!flush) begin
                if (dc_ready) begin
                    hi_wdata <= dc_result[2*DATA_W-1:DATA_W];
                    lo_wdata <= dc_result[DATA_W-1:0];
                end else if (timeout_hit) begin
                    hi_wdata    <= '0;
                    lo_wdata    <= '0;
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomised bench for div_ctrl with a behavioural divider core and a scoreboard
// that checks every HI/LO write against results predicted from the issued operands.
module tb_div_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        dc_start;
    logic        dc_signed;
    logic [31:0] dc_a;
    logic [31:0] dc_b;
    logic        dc_annul;
    logic [63:0] dc_result;
    logic        dc_ready;
    logic        div_stall;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    int   core_lat  = 0;
    int   wcnt      = 0;
    logic core_rdy  = 1'b0;
    logic stray_rdy = 1'b0;

    assign dc_ready = core_rdy | stray_rdy;

    div_ctrl #(.TIMEOUT(TIMEOUT), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_signed(op_signed),
        .op_a(op_a), .op_b(op_b), .flush(flush), .dc_start(dc_start),
        .dc_signed(dc_signed), .dc_a(dc_a), .dc_b(dc_b), .dc_annul(dc_annul),
        .dc_result(dc_result), .dc_ready(dc_ready), .div_stall(div_stall),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Core model: ready on the core_lat-th cycle of start; core_lat==0 never answers.
    always @(negedge clk) begin
        if (dc_start) begin
            wcnt      = wcnt + 1;
            core_rdy  = (core_lat != 0) && (wcnt == core_lat);
            dc_result = ref_div(dc_a, dc_b, dc_signed);
        end else begin
            wcnt     = 0;
            core_rdy = 1'b0;
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every HI/LO write must match the oldest outstanding prediction.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1 && hilo_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL hilo_unexpected actual=%h required=no_write", {hi_wdata, lo_wdata});
                end else begin
                    e = exp_q.pop_front();
                    if ({hi_wdata, lo_wdata} !== e) begin
                        errors++;
                        $display("FAIL hilo_data actual=%h required=%h", {hi_wdata, lo_wdata}, e);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int lat, input int flush_at, input bit keep);
        int          stall_n;
        int          annul_n;
        int          exp_stall;
        int          exp_annul;
        bit          start_seen;
        bit          stable_ok;
        bit          done;
        bit          will_write;
        logic [63:0] exp;
        exp = ref_div(a, b, sgn);
        will_write = (b == 0) || (flush_at == 0);
        if (b == 0) begin
            exp_stall = 1; exp_annul = 0;
        end else if (flush_at > 0) begin
            exp_stall = flush_at; exp_annul = 1;
        end else if (lat == 0) begin
            exp_stall = TIMEOUT + 1; exp_annul = 1; exp = 64'd0;
        end else begin
            exp_stall = lat + 1; exp_annul = 0;
        end
        core_lat = lat;
        @(negedge clk);
        op_valid = 1'b1; op_a = a; op_b = b; op_signed = sgn;
        if (will_write) exp_q.push_back(exp);
        #1;
        stall_n = div_stall ? 1 : 0;
        start_seen = dc_start;
        annul_n = dc_annul ? 1 : 0;
        stable_ok = 1'b1;
        done = 1'b0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            if (c == flush_at) flush = 1'b1;
            #1;
            if (dc_start) begin
                start_seen = 1'b1;
                if (dc_a !== a || dc_b !== b || dc_signed !== sgn) stable_ok = 1'b0;
            end
            if (dc_annul) annul_n++;
            if (div_stall) stall_n++;
            else begin
                done = 1'b1;
                check("we_at_end", 64'(hilo_we), 64'(will_write));
                check("operands_held", {dc_a, dc_b}, {a, b});
                if (will_write) check("start_low_in_done", 64'(dc_start), 64'd0);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL cycle_budget actual=no_completion required=stall_drop");
        end
        check("stall_cycles", 64'(stall_n), 64'(exp_stall));
        check("annul_pulses", 64'(annul_n), 64'(exp_annul));
        if (b == 0) check("div0_no_start", 64'(start_seen), 64'd0);
        else        check("operands_stable", 64'(stable_ok), 64'd1);
        if (!keep || flush_at > 0) begin
            @(negedge clk);
            flush = 1'b0; op_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        rst = 1'b0; op_valid = 1'b1; op_signed = 1'b1;
        op_a = 32'h1234; op_b = 32'h5; flush = 1'b0; dc_result = '0;
        #2;
        check("reset_ctrl", 64'({dc_start, dc_annul, dc_signed, hilo_we, div_stall, err_timeout}), 64'd0);
        check("reset_data", {dc_a, dc_b}, 64'd0);
        check("reset_hilo", {hi_wdata, lo_wdata}, 64'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 33, 0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 5, 0, 0);
        run_op(32'd5, 32'd0, 1'b0, 0, 0, 0);
        run_op(32'd1000, 32'd3, 1'b0, 33, 10, 0);
        run_op(32'd9, 32'd3, 1'b0, 7, 0, 0);

        // A stray ready outside WAIT must not cause a write or start.
        @(negedge clk); stray_rdy = 1'b1;
        #1; check("stray_ready_idle", 64'({dc_start, hilo_we, div_stall}), 64'd0);
        @(negedge clk); stray_rdy = 1'b0;

        run_op(32'd77, 32'd6, 1'b0, 3, 0, 1);
        run_op(32'd50, 32'd0, 1'b0, 0, 0, 1);
        run_op(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, 40, 0, 0);
        check("no_timeout_yet", 64'(err_timeout), 64'd0);

        run_op(32'd1000, 32'd10, 1'b0, 0, 0, 0);
        check("timeout_flag", 64'(err_timeout), 64'd1);
        run_op(32'd81, 32'd9, 1'b0, 12, 0, 0);
        check("timeout_sticky", 64'(err_timeout), 64'd1);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            run_op(ra, rb, rs, $urandom_range(1, TIMEOUT), 0, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a wait.
        @(negedge clk);
        core_lat = 33; op_valid = 1'b1; op_a = 32'd50; op_b = 32'd5; op_signed = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        check("pre_reset_busy", 64'({dc_start, div_stall}), 64'd3);
        rst = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({dc_start, dc_annul, dc_signed, hilo_we, div_stall, err_timeout}), 64'd0);
        check("async_reset_data", {dc_a, dc_b}, 64'd0);
        check("async_reset_hilo", {hi_wdata, lo_wdata}, 64'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd50, 32'd5, 1'b0, 20, 0, 0);
        check("timeout_cleared", 64'(err_timeout), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
